// File: rtl/intersection_ctrl.sv
// Two-way intersection phase sequencer: NS/EW green, yellow+all-red clearance, arm, request latching.
// Optional build macro INTERSECTION_NIGHT_EN adds a night input that parks the controller in OFF.
//
// state  | meaning
// -------+-----------------------------------------------------------
// OFF    | controller idle, all heads disabled
// INIT   | 2-cycle head initialisation (NS green, EW red)
// NS_GO  | NS green; ends on MIN_GREEN with EW pending, or on MAX_GREEN
// NS_CLR | NS clearance: yellow plus all-red
// EW_ARM | EW heads switching toward green
// EW_GO  | EW green; ends on MIN_GREEN with NS pending, or on MAX_GREEN
// EW_CLR | EW clearance: yellow plus all-red
// NS_ARM | NS heads switching toward green
module intersection_ctrl #(
  parameter int unsigned MIN_GREEN  = 2000,
  parameter int unsigned MAX_GREEN  = 20000,
  parameter int unsigned YEL_CYC    = 30000,
  parameter int unsigned ALLRED_CYC = 1000
) (
  input  logic       clklf,
  input  logic       reset,
  input  logic       run,
  input  logic       req_ns,
  input  logic       req_ew,
`ifdef INTERSECTION_NIGHT_EN
  input  logic       night,
`endif
  output logic       en_ns,
  output logic       set_ns,
  output logic       chg_ns,
  output logic       en_ew,
  output logic       set_ew,
  output logic       chg_ew,
  output logic       grant_ns,
  output logic       grant_ew,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    INIT   = 3'd1,
    NS_GO  = 3'd2,
    NS_CLR = 3'd3,
    EW_ARM = 3'd4,
    EW_GO  = 3'd5,
    EW_CLR = 3'd6,
    NS_ARM = 3'd7
  } state_t;

  // Terminal-count values: counter reads 0 on the first cycle of each state.
  localparam logic [15:0] INIT_LAST = 16'd1;
  localparam logic [15:0] MIN_LAST  = 16'((MIN_GREEN > 0) ? MIN_GREEN - 1 : 0);
  localparam logic [15:0] MAX_LAST  = 16'((MAX_GREEN > 0) ? MAX_GREEN - 1 : 0);
  localparam logic [15:0] CLR_LAST  = 16'(((YEL_CYC + ALLRED_CYC) > 0) ? YEL_CYC + ALLRED_CYC - 1 : 0);
  localparam logic [15:0] ARM_LAST  = 16'((YEL_CYC > 0) ? YEL_CYC - 1 : 0);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_ns_q, pend_ns_d;
  logic        pend_ew_q, pend_ew_d;
  logic        chg_ns_q, chg_ns_d;
  logic        chg_ew_q, chg_ew_d;
  logic        grant_ns_q, grant_ns_d;
  logic        grant_ew_q, grant_ew_d;
  logic        night_i;
  logic        entering;

`ifdef INTERSECTION_NIGHT_EN
  assign night_i = night;
`else
  assign night_i = 1'b0;
`endif

  always_ff @(posedge clklf) begin
    if (reset) begin
      state_q    <= OFF;
      cnt_q      <= 16'd0;
      pend_ns_q  <= 1'b0;
      pend_ew_q  <= 1'b0;
      chg_ns_q   <= 1'b0;
      chg_ew_q   <= 1'b0;
      grant_ns_q <= 1'b0;
      grant_ew_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_ns_q  <= pend_ns_d;
      pend_ew_q  <= pend_ew_d;
      chg_ns_q   <= chg_ns_d;
      chg_ew_q   <= chg_ew_d;
      grant_ns_q <= grant_ns_d;
      grant_ew_q <= grant_ew_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF:    if (run && !night_i) state_d = INIT;
      INIT:   if (cnt_q == INIT_LAST) state_d = NS_GO;
      NS_GO:  if ((cnt_q >= MIN_LAST && pend_ew_q) || cnt_q == MAX_LAST) state_d = NS_CLR;
      NS_CLR: if (cnt_q == CLR_LAST) state_d = EW_ARM;
      EW_ARM: if (cnt_q == ARM_LAST) state_d = EW_GO;
      EW_GO:  if ((cnt_q >= MIN_LAST && pend_ns_q) || cnt_q == MAX_LAST) state_d = EW_CLR;
      EW_CLR: if (cnt_q == CLR_LAST) state_d = NS_ARM;
      NS_ARM: if (cnt_q == ARM_LAST) state_d = NS_GO;
      default: state_d = OFF;
    endcase
    if (night_i && (state_q == NS_GO || state_q == EW_GO)) state_d = OFF;
    if (!run) state_d = OFF;

    entering = (state_d != state_q);
    cnt_d    = entering ? 16'd0 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);

    chg_ns_d   = entering && (state_d == NS_CLR || state_d == NS_ARM);
    chg_ew_d   = entering && (state_d == EW_CLR || state_d == EW_ARM);
    grant_ew_d = entering && (state_d == EW_GO);
    // Startup NS green comes from INIT and is not a service acknowledge.
    grant_ns_d = entering && (state_d == NS_GO) && (state_q == NS_ARM);

    // A request coinciding with its grant is considered served.
    pend_ns_d = grant_ns_q ? 1'b0 : (pend_ns_q | req_ns);
    pend_ew_d = grant_ew_q ? 1'b0 : (pend_ew_q | req_ew);
  end

  assign en_ns    = (state_q != OFF);
  assign en_ew    = (state_q != OFF);
  assign set_ns   = 1'b0;
  assign set_ew   = (state_q != OFF);
  assign chg_ns   = chg_ns_q;
  assign chg_ew   = chg_ew_q;
  assign grant_ns = grant_ns_q;
  assign grant_ew = grant_ew_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl with MIN_GREEN=4, MAX_GREEN=8, YEL_CYC=3, ALLRED_CYC=2.
module tb_intersection_ctrl;
  logic       clklf = 1'b0;
  logic       reset, run, req_ns, req_ew;
`ifdef INTERSECTION_NIGHT_EN
  logic       night;
`endif
  logic       en_ns, set_ns, chg_ns, en_ew, set_ew, chg_ew, grant_ns, grant_ew;
  logic [2:0] phase;

  int checks = 0;
  int failures = 0;
  int len;

  intersection_ctrl #(
    .MIN_GREEN(4), .MAX_GREEN(8), .YEL_CYC(3), .ALLRED_CYC(2)
  ) dut (
    .clklf(clklf), .reset(reset), .run(run), .req_ns(req_ns), .req_ew(req_ew),
`ifdef INTERSECTION_NIGHT_EN
    .night(night),
`endif
    .en_ns(en_ns), .set_ns(set_ns), .chg_ns(chg_ns),
    .en_ew(en_ew), .set_ew(set_ew), .chg_ew(chg_ew),
    .grant_ns(grant_ns), .grant_ew(grant_ew), .phase(phase)
  );

  always #5 clklf = ~clklf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts cycles spent in phase p starting at the current sample point.
  task automatic measure(input logic [2:0] p, output int n);
    n = 0;
    while (phase === p && n < 200) begin
      n++;
      @(negedge clklf);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; req_ns = 1'b0; req_ew = 1'b0;
`ifdef INTERSECTION_NIGHT_EN
    night = 1'b0;
`endif
    repeat (2) @(negedge clklf);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_outs", 32'({en_ns, set_ns, chg_ns, en_ew, set_ew, chg_ew, grant_ns, grant_ew}), 0);

    // Startup: OFF -> INIT x2 -> NS_GO, no grant
    reset = 1'b0; run = 1'b1;
    @(negedge clklf);
    chk("init_phase0", 32'(phase), 1);
    chk("init_heads", 32'({en_ns, en_ew, set_ns, set_ew}), 32'b1101);
    @(negedge clklf);
    chk("init_phase1", 32'(phase), 1);
    @(negedge clklf);
    chk("nsgo_entry", 32'(phase), 2);
    chk("nsgo_nogrant", 32'(grant_ns), 0);

    // No requests: MAX_GREEN alternation
    measure(3'd2, len); chk("ns_go_max_len", 32'(len), 8);
    chk("ns_clr_phase", 32'(phase), 3);
    chk("ns_clr_chg", 32'(chg_ns), 1);
    @(negedge clklf);
    chk("ns_clr_chg_1cyc", 32'(chg_ns), 0);
    measure(3'd3, len); chk("ns_clr_len_rest", 32'(len), 4);
    chk("ew_arm_phase", 32'(phase), 4);
    chk("ew_arm_chg", 32'({chg_ns, chg_ew}), 32'b01);
    measure(3'd4, len); chk("ew_arm_len", 32'(len), 3);
    chk("ew_go_phase", 32'(phase), 5);
    chk("ew_go_grant", 32'(grant_ew), 1);
    measure(3'd5, len); chk("ew_go_max_len", 32'(len), 8);
    chk("ew_clr_chg", 32'({phase, chg_ew}), 32'({3'd6, 1'b1}));
    measure(3'd6, len); chk("ew_clr_len", 32'(len), 5);
    chk("ns_arm_chg", 32'({phase, chg_ns}), 32'({3'd7, 1'b1}));
    measure(3'd7, len); chk("ns_arm_len", 32'(len), 3);
    chk("ns_go_grant", 32'({phase, grant_ns}), 32'({3'd2, 1'b1}));

    // req_ew pulse at NS_GO cycle 1 ends NS_GO after MIN_GREEN (4 cycles)
    @(negedge clklf);
    req_ew = 1'b1;
    @(negedge clklf);
    req_ew = 1'b0;
    measure(3'd2, len); chk("ns_go_min_rest", 32'(len), 2);
    chk("ns_clr_chg_b", 32'({phase, chg_ns}), 32'({3'd3, 1'b1}));
    measure(3'd3, len); chk("ns_clr_len_b", 32'(len), 5);
    chk("ew_arm_chg_b", 32'(chg_ew), 1);
    measure(3'd4, len); chk("ew_arm_len_b", 32'(len), 3);
    chk("ew_grant_b", 32'({phase, grant_ew}), 32'({3'd5, 1'b1}));

    // req_ew on the grant_ew cycle is absorbed; next NS_GO runs to MAX_GREEN
    req_ew = 1'b1;
    @(negedge clklf);
    req_ew = 1'b0;
    chk("ew_grant_1cyc", 32'(grant_ew), 0);
    measure(3'd5, len); chk("ew_go_green_req", 32'(len), 7);
    measure(3'd6, len); chk("ew_clr_len_c", 32'(len), 5);
    measure(3'd7, len); chk("ns_arm_len_c", 32'(len), 3);
    chk("ns_grant_c", 32'({phase, grant_ns}), 32'({3'd2, 1'b1}));
    measure(3'd2, len); chk("ns_go_absorbed", 32'(len), 8);

    // run=0 in NS_CLR forces OFF; pending req_ew survives
    chk("d_in_ns_clr", 32'(phase), 3);
    req_ew = 1'b1;
    @(negedge clklf);
    req_ew = 1'b0; run = 1'b0;
    @(negedge clklf);
    chk("off_phase", 32'(phase), 0);
    chk("off_outs", 32'({en_ns, en_ew, set_ew, chg_ns, chg_ew, grant_ns, grant_ew}), 0);
    @(negedge clklf);
    chk("off_hold", 32'(phase), 0);
    run = 1'b1;
    @(negedge clklf);
    chk("rerun_init", 32'(phase), 1);
    @(negedge clklf);
    @(negedge clklf);
    chk("rerun_nsgo", 32'({phase, grant_ns}), 32'({3'd2, 1'b0}));
    measure(3'd2, len); chk("pend_kept_len", 32'(len), 4);
    measure(3'd3, len); chk("ns_clr_len_d", 32'(len), 5);
    measure(3'd4, len); chk("ew_arm_len_d", 32'(len), 3);
    chk("ew_grant_d", 32'({phase, grant_ew}), 32'({3'd5, 1'b1}));

    // req_ns during EW_GO ends it after MIN_GREEN
    @(negedge clklf);
    req_ns = 1'b1;
    @(negedge clklf);
    req_ns = 1'b0;
    measure(3'd5, len); chk("ew_go_min_rest", 32'(len), 2);
    chk("ew_clr_chg_e", 32'({phase, chg_ew}), 32'({3'd6, 1'b1}));

    // Mid-phase reset wins over run and requests, emits no chg
    @(negedge clklf);
    reset = 1'b1; req_ew = 1'b1; req_ns = 1'b1;
    @(negedge clklf);
    chk("midrst_phase", 32'(phase), 0);
    chk("midrst_outs", 32'({en_ns, set_ns, chg_ns, en_ew, set_ew, chg_ew, grant_ns, grant_ew}), 0);
    req_ew = 1'b0; req_ns = 1'b0;
    @(negedge clklf);
    chk("midrst_hold", 32'(phase), 0);
    reset = 1'b0;
    @(negedge clklf);
    chk("postrst_init", 32'(phase), 1);
    @(negedge clklf);
    @(negedge clklf);
    chk("postrst_nsgo", 32'(phase), 2);
    measure(3'd2, len); chk("postrst_no_pend", 32'(len), 8);

`ifdef INTERSECTION_NIGHT_EN
    measure(3'd3, len); chk("n_ns_clr_len", 32'(len), 5);
    measure(3'd4, len); chk("n_ew_arm_len", 32'(len), 3);
    chk("n_ew_go", 32'(phase), 5);
    night = 1'b1;
    @(negedge clklf);
    chk("night_off", 32'({phase, en_ns, en_ew}), 0);
    @(negedge clklf);
    chk("night_hold", 32'(phase), 0);
    night = 1'b0;
    @(negedge clklf);
    chk("night_init", 32'(phase), 1);
    @(negedge clklf);
    @(negedge clklf);
    chk("night_nsgo", 32'(phase), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 The block SHALL have parameter MIN_GREEN, default 2000, minimum green cycles before a request can end a phase.
REQ-002 The block SHALL have parameter MAX_GREEN, default 20000, green cycles after which the phase ends unconditionally; MIN_GREEN <= MAX_GREEN < 65536.
REQ-003 The block SHALL have parameter YEL_CYC, default 30000, yellow duration in cycles; >= 1.
REQ-004 The block SHALL have parameter ALLRED_CYC, default 1000, all-red gap in cycles; >= 0.
REQ-005 The block SHALL have port clklf, input, 1 bit, clock.
REQ-006 The block SHALL have port reset, input, 1 bit; reset is synchronous, active-high; clock is clklf.
REQ-007 The block SHALL have port run, input, 1 bit, controller enable.
REQ-008 The block SHALL have ports req_ns and req_ew, inputs, 1 bit each, service requests from pedestrian or vehicle sensors.
REQ-009 The block SHALL have ports en_ns, set_ns, chg_ns, en_ew, set_ew, chg_ew, outputs, 1 bit each, the en/set/change controls of the two signal heads.
REQ-010 The block SHALL have ports grant_ns and grant_ew, outputs, 1 bit each, one-cycle service acknowledges.
REQ-011 The block SHALL have port phase, output, 3 bits, current state encoding.

Function
REQ-012 The FSM SHALL use these states and encodings: OFF=0, INIT=1, NS_GO=2, NS_CLR=3, EW_ARM=4, EW_GO=5, EW_CLR=6, NS_ARM=7; phase SHALL equal the current state.
REQ-013 In OFF, all en/set/chg/grant outputs SHALL be 0; run=1 SHALL move the FSM to INIT on the next edge.
REQ-014 INIT SHALL last 2 cycles with en_ns=en_ew=1, set_ns=0 and set_ew=1 (NS heads green, EW heads red), then SHALL enter NS_GO; set_* SHALL hold these values in every non-OFF state.
REQ-015 A 16-bit phase counter SHALL clear on every state entry and SHALL increment each cycle, saturating at 65535.
REQ-016 NS_GO SHALL exit to NS_CLR when (cnt >= MIN_GREEN-1 and pend_ew) or cnt == MAX_GREEN-1; EW_GO SHALL exit symmetrically to EW_CLR using pend_ns.
REQ-017 chg_ns SHALL pulse for exactly 1 cycle on the first cycle of NS_CLR and of NS_ARM; chg_ew SHALL pulse likewise on the first cycle of EW_CLR and of EW_ARM; all chg outputs SHALL be registered.
REQ-018 NS_CLR and EW_CLR SHALL each last YEL_CYC+ALLRED_CYC cycles, then enter EW_ARM and NS_ARM respectively.
REQ-019 EW_ARM and NS_ARM SHALL each last YEL_CYC cycles, then enter EW_GO and NS_GO respectively.
REQ-020 grant_ew SHALL pulse for 1 cycle on EW_GO entry and SHALL clear pend_ew; grant_ns SHALL behave the same on NS_GO entry, except at the INIT-to-NS_GO transition, which produces no grant.
REQ-021 pend_x SHALL set on any cycle with req_x=1 and SHALL clear only on grant_x; a req_x arriving in the same cycle as grant_x SHALL be absorbed (pend_x=0).
REQ-022 A request for the direction that is already green SHALL be latched and SHALL have no effect on phase length.
REQ-023 run=0 in any state SHALL force OFF on the next edge, dropping all en outputs; pending requests SHALL be retained.
REQ-024 With no requests pending, the FSM SHALL alternate on MAX_GREEN timeouts.

Reset
REQ-025 On reset the FSM SHALL enter OFF; the counter, pend_ns, pend_ew and all outputs SHALL clear to 0; phase SHALL be 0.
REQ-026 Reset SHALL take priority over run and requests in the same cycle, and reset in mid-phase SHALL abort immediately without emitting a chg pulse.

Configuration
REQ-027 With INTERSECTION_NIGHT_EN defined, input night (1 bit) SHALL exist; night=1 in NS_GO or EW_GO SHALL drive FSM to OFF and hold it there while night=1, then resume via INIT when night=0 and run=1.
REQ-028 With INTERSECTION_NIGHT_EN undefined, the night port and logic SHALL be absent, and the FSM SHALL leave OFF only via run.

Verification
REQ-029 Reset, then run=1 -> phase 0, 1, 1, then 2; en_ns=en_ew=1, set_ew=1, no grant pulse.
REQ-030 MIN_GREEN=4, req_ew pulse at NS_GO cycle 1 -> chg_ns at NS_GO cycle 4+1; chg_ew after YEL_CYC+ALLRED_CYC; grant_ew after a further YEL_CYC.
REQ-031 No requests, MAX_GREEN=8 -> NS_GO lasts exactly 8 cycles, then EW_GO lasts 8 cycles, alternating indefinitely.
REQ-032 req_ew asserted on the grant_ew cycle -> pend_ew=0; the following EW_GO lasts until MAX_GREEN unless req_ns arrives.
REQ-033 run=0 during NS_CLR -> next cycle phase=0 with all en=0; run=1 -> INIT, and a prior pending req_ew is honoured after MIN_GREEN.
REQ-034 INTERSECTION_NIGHT_EN defined, night=1 in EW_GO -> OFF next cycle; night=0 -> INIT and then NS_GO.
